vga_fb_arbiter: RTL
===================

// Module: vga_fb_arbiter
// PURPOSE
//  Shares one single-port, 1-cycle-read framebuffer RAM between the VGA scanout and one MCU requester.
//  Scanout is driven by ROW/COLUMN from the VGA driver; each framebuffer cell covers a 2^SCALE_SH x 2^SCALE_SH pixel block.
//  Scanout owns the RAM only in fixed fetch slots. All other cycles belong to the MCU.
//  Outputs RED/GREEN/BLUE back to the VGA driver, plus a REQ/ACK read/write port to the MCU.
// PARAMETERS
//  FB_COLS   80   cells per row (valid col_idx 0..FB_COLS-1)
//  FB_ROWS   60   cell rows (valid row_idx 0..FB_ROWS-1)
//  COL_W     7    col_idx field width
//  ROW_W     6    row_idx field width; ADDR_W = ROW_W+COL_W
//  SCALE_SH  3    log2 of pixels per cell edge
//  H_TOTAL   800  COLUMN values per line (0..H_TOTAL-1)
//  V_TOTAL   525  ROW values per frame (0..V_TOTAL-1)
// PORTS
//  CLK        in   1       pixel clock (25 MHz)
//  RST_N      in   1       reset, asynchronous, active-low
//  ROW        in   10      current row from VGA driver
//  COLUMN     in   10      current column from VGA driver
//  RED        out  3       pixel red   = pix[7:5]
//  GREEN      out  3       pixel green = pix[4:2]
//  BLUE       out  2       pixel blue  = pix[1:0]
//  CPU_REQ    in   1       MCU request; held with ADDR/WE/WDATA stable until ACK
//  CPU_WE     in   1       1 = write, 0 = read
//  CPU_ADDR   in   ADDR_W  {row_idx, col_idx}
//  CPU_WDATA  in   8       write pixel RRRGGGBB
//  CPU_RDATA  out  8       read data; valid while CPU_ACK = 1
//  CPU_ACK    out  1       one-cycle completion pulse
//  FB_ADDR    out  ADDR_W  RAM address, combinational
//  FB_WE      out  1       RAM write enable, combinational
//  FB_WDATA   out  8       RAM write data
//  FB_RDATA   in   8       RAM read data for the address of the previous cycle
// BEHAVIOUR
//  Reset (RST_N = 0, async):
//   - pix, CPU_RDATA, CPU_ACK, FB_WE and FB_ADDR are 0; FSM goes to IDLE.
//   - An in-flight MCU transaction is abandoned and no ACK is issued for it.
//  Scan slot (scanout owns the RAM, FB_WE = 0). Two cases:
//   - a) ROW < 480 and COLUMN[SCALE_SH-1:0] = 2^SCALE_SH-2:
//     FB_ADDR = {ROW>>SCALE_SH, (COLUMN>>SCALE_SH)+1}.
//     No slot when (COLUMN>>SCALE_SH)+1 >= FB_COLS.
//   - b) COLUMN = H_TOTAL-2: FB_ADDR = {nr>>SCALE_SH, 0}, where nr = (ROW = V_TOTAL-1) ? 0 : ROW+1.
//     No slot when nr >= 480.
//  Pixel capture:
//   - The cycle after a scan slot, FB_RDATA is latched into pix at the clock edge.
//   - New pix therefore appears when COLUMN reaches the first column of the fetched cell.
//   - pix holds otherwise; blanking is done downstream in the VGA driver.
//  MCU FSM:
//   - IDLE: if CPU_REQ and not a scan slot, issue the access and go to WAIT.
//     FB_ADDR = CPU_ADDR; FB_WE = CPU_WE and in_range; FB_WDATA = CPU_WDATA.
//     in_range means col_idx < FB_COLS and row_idx < FB_ROWS.
//     If CPU_REQ arrives in a scan slot, the request stalls one cycle.
//   - WAIT: CPU_RDATA <= (read and in_range) ? FB_RDATA : 8'h00. Go to ACK.
//     The RAM is free in WAIT and may take a scan slot.
//   - ACK: CPU_ACK = 1 for exactly one cycle; CPU_RDATA holds. Go to IDLE.
//   - Latency is issue cycle N -> ACK in cycle N+2, for reads and writes.
//   - The requester drops CPU_REQ at the edge where it samples ACK. If REQ is still high in IDLE, a new transaction starts.
//  Out-of-range MCU address: the write is dropped (FB_WE never 1), a read returns 8'h00, and ACK is still issued.
//  RAM read ownership follows the previous cycle. The scan and MCU never issue in the same cycle.
//  When idle, FB_ADDR = 0 and FB_WE = 0.
// TESTING
//  1. Pull RST_N low mid-transaction (in WAIT). Outputs go 0 asynchronously, and no ACK follows after release.
//  2. Preload RAM[0x0001] = 8'hE0. With ROW = 0, COLUMN = 6: FB_ADDR = 0x0001, FB_WE = 0.
//     At COLUMN = 8: RED = 7, GREEN = 0, BLUE = 0.
//  3. Line wrap fetches:
//     - ROW = 7, COLUMN = 798 -> FB_ADDR = 0x0080.
//     - ROW = 524, COLUMN = 798 -> FB_ADDR = 0x0000.
//     - ROW = 479, COLUMN = 798 -> no slot; an MCU request is issued in that cycle.
//  4. Write REQ (ADDR = 0x0085, WDATA = 8'h1C) raised at ROW = 0, COLUMN = 6.
//     It is issued at COLUMN = 7 with FB_WE = 1, and CPU_ACK pulses at COLUMN = 9.
//  5. A read of 0x0085 after test 4 returns CPU_ACK two cycles after issue with CPU_RDATA = 8'h1C.
//  6. Write to ADDR = 0x0050 (col 80): FB_WE stays 0 and ACK pulses.
//     A read of 0x0050 acks with CPU_RDATA = 8'h00.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: the VGA scanout owns the single-port RAM in fixed fetch slots,
// and the MCU REQ/ACK port gets every other cycle.
module vga_fb_arbiter #(
  parameter int FB_COLS  = 80,
  parameter int FB_ROWS  = 60,
  parameter int COL_W    = 7,
  parameter int ROW_W    = 6,
  parameter int SCALE_SH = 3,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  localparam int ADDR_W  = ROW_W + COL_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [9:0]        ROW,
  input  logic [9:0]        COLUMN,
  output logic [2:0]        RED,
  output logic [2:0]        GREEN,
  output logic [1:0]        BLUE,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [7:0]        CPU_WDATA,
  output logic [7:0]        CPU_RDATA,
  output logic              CPU_ACK,
  output logic [ADDR_W-1:0] FB_ADDR,
  output logic              FB_WE,
  output logic [7:0]        FB_WDATA,
  input  logic [7:0]        FB_RDATA
);

  localparam int                VIS_ROWS = FB_ROWS << SCALE_SH;
  localparam logic [SCALE_SH-1:0] FETCH_PH = SCALE_SH'((1 << SCALE_SH) - 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic                scan_d_r;
  logic [7:0]          pix_r;
  logic [7:0]          cpu_rdata_r;
  logic                cpu_ack_r;
  logic                rd_ok_r;

  logic [9:0]          col_cell_s;
  logic [9:0]          next_cell_s;
  logic [9:0]          next_row_s;
  logic                scan_slot_s;
  logic                scan_go_s;
  logic [ADDR_W-1:0]   scan_addr_s;
  logic                issue_s;
  logic                cpu_in_range_s;
  logic [ADDR_W-1:0]   fb_addr_s;
  logic                fb_we_s;
  logic [7:0]          fb_wdata_s;

  // True when {row_idx, col_idx} names a real framebuffer cell.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    logic [ROW_W-1:0] r;
    logic [COL_W-1:0] c;
    r = a[ADDR_W-1:COL_W];
    c = a[COL_W-1:0];
    return (32'(c) < FB_COLS) && (32'(r) < FB_ROWS);
  endfunction

  // Scan fetch slot decode: mid-cell prefetch of the next cell, or end-of-line prefetch of the next row.
  always_comb begin
    col_cell_s  = COLUMN >> SCALE_SH;
    next_cell_s = col_cell_s + 10'd1;
    next_row_s  = (ROW == 10'(V_TOTAL - 1)) ? 10'd0 : ROW + 10'd1;
    scan_slot_s = 1'b0;
    scan_addr_s = {ADDR_W{1'b0}};
    if (COLUMN == 10'(H_TOTAL - 2)) begin
      if (next_row_s < 10'(VIS_ROWS)) begin
        scan_slot_s = 1'b1;
        scan_addr_s = {ROW_W'(next_row_s >> SCALE_SH), {COL_W{1'b0}}};
      end else begin
        scan_slot_s = 1'b0;
      end
    end else if ((ROW < 10'(VIS_ROWS)) && (COLUMN[SCALE_SH-1:0] == FETCH_PH) &&
                 (next_cell_s < 10'(FB_COLS))) begin
      scan_slot_s = 1'b1;
      scan_addr_s = {ROW_W'(ROW >> SCALE_SH), next_cell_s[COL_W-1:0]};
    end else begin
      scan_slot_s = 1'b0;
    end
    // Nothing reaches the RAM while reset is held.
    scan_go_s = scan_slot_s && RST_N;
  end

  // MCU FSM next state plus the RAM port mux; scanout always wins its slot.
  always_comb begin
    state_s        = state_r;
    issue_s        = 1'b0;
    cpu_in_range_s = addr_in_range(CPU_ADDR);
    fb_addr_s      = {ADDR_W{1'b0}};
    fb_we_s        = 1'b0;
    fb_wdata_s     = 8'h00;
    case (state_r)
      ST_IDLE: begin
        if (CPU_REQ && !scan_slot_s && RST_N) begin
          issue_s = 1'b1;
          state_s = ST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: state_s = ST_ACK;
      ST_ACK:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
    if (scan_go_s) begin
      fb_addr_s = scan_addr_s;
    end else if (issue_s) begin
      fb_addr_s  = CPU_ADDR;
      fb_we_s    = CPU_WE && cpu_in_range_s;
      fb_wdata_s = CPU_WDATA;
    end else begin
      fb_addr_s = {ADDR_W{1'b0}};
    end
  end

  // State, pixel capture and MCU response registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r     <= ST_IDLE;
      scan_d_r    <= 1'b0;
      pix_r       <= 8'h00;
      cpu_rdata_r <= 8'h00;
      cpu_ack_r   <= 1'b0;
      rd_ok_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      scan_d_r  <= scan_go_s;
      cpu_ack_r <= (state_r == ST_WAIT);
      if (scan_d_r) begin
        pix_r <= FB_RDATA;
      end
      if (issue_s) begin
        rd_ok_r <= !CPU_WE && cpu_in_range_s;
      end
      // FB_RDATA in WAIT belongs to the MCU access issued the cycle before.
      if (state_r == ST_WAIT) begin
        cpu_rdata_r <= rd_ok_r ? FB_RDATA : 8'h00;
      end
    end
  end

  assign RED       = pix_r[7:5];
  assign GREEN     = pix_r[4:2];
  assign BLUE      = pix_r[1:0];
  assign CPU_RDATA = cpu_rdata_r;
  assign CPU_ACK   = cpu_ack_r;
  assign FB_ADDR   = fb_addr_s;
  assign FB_WE     = fb_we_s;
  assign FB_WDATA  = fb_wdata_s;

endmodule
